udcnt_arb_ctrl: RTL and testbench

Arbiter and sequencer for a shared up/down step counter. Two requesters each ask for a run of N steps in a chosen direction. The block grants the counter to one requester at a time, using round-robin between them. It steps the counter once per clock for exactly N cycles, then returns a one-cycle completion pulse. The counter value persists across transactions, so both requesters share a single position register.

---
 rtl/udcnt_arb_ctrl.sv | 113 +++++++++++
 tb/tb_udcnt_arb_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/udcnt_arb_ctrl.sv
// Round-robin arbiter and sequencer for a shared up/down step counter.
// Two requesters each ask for N steps; the winner's run always completes before the next grant.
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for a request; the winner is picked on the edge
// RUN   | one counter step per clock until rem reaches zero
// DONE  | one-cycle completion pulse; lp takes sel on the exit edge
module udcnt_arb_ctrl #(
  parameter int WIDTH = 4,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             dir0,
  input  logic [LEN_W-1:0] len0,
  input  logic             req1,
  input  logic             dir1,
  input  logic [LEN_W-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             u_d,
  output logic             tc
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               sel_q, sel_d;
  logic               lp_q, lp_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               ud_q, ud_d;
  logic               tc_q, tc_d;
  logic               win;
  logic [LEN_W-1:0]   len_sel;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
      sel_q   <= 1'b0;
      lp_q    <= 1'b1;
      q_q     <= '0;
      ud_q    <= 1'b1;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      sel_q   <= sel_d;
      lp_q    <= lp_d;
      q_q     <= q_d;
      ud_q    <= ud_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    sel_d   = sel_q;
    lp_d    = lp_q;
    q_d     = q_q;
    ud_d    = ud_q;
    tc_d    = 1'b0;
    win     = 1'b0;
    len_sel = '0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the requester not served last wins.
          win     = (req0 && req1) ? ~lp_q : req1;
          len_sel = win ? len1 : len0;
          sel_d   = win;
          ud_d    = win ? dir1 : dir0;
          rem_d   = len_sel;
          state_d = (len_sel != '0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (ud_q) begin
          q_d  = q_q + 1'b1;
          tc_d = &q_q;
        end else begin
          q_d  = q_q - 1'b1;
          tc_d = ~|q_q;
        end
        rem_d = rem_q - 1'b1;
        if (rem_q == LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        lp_d    = sel_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q != IDLE);
  assign gnt0  = busy && !sel_q;
  assign gnt1  = busy && sel_q;
  assign done0 = (state_q == DONE) && !sel_q;
  assign done1 = (state_q == DONE) && sel_q;
  assign q     = q_q;
  assign u_d   = ud_q;
  assign tc    = tc_q;

endmodule

// File: tb/tb_udcnt_arb_ctrl.sv
// Bench for udcnt_arb_ctrl: directed vector table, hand-written corner sequences
// and random traffic compared against a transaction-level reference model.
module tb_udcnt_arb_ctrl;

  logic       clk, rst;
  logic       req0, dir0, req1, dir1;
  logic [3:0] len0, len1;
  logic       gnt0, gnt1, done0, done1, busy, u_d, tc;
  logic [3:0] q;

  int compared = 0;
  int mismatched = 0;

  udcnt_arb_ctrl #(.WIDTH(4), .LEN_W(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .dir0(dir0), .len0(len0),
    .req1(req1), .dir1(dir1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .busy(busy), .q(q), .u_d(u_d), .tc(tc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which requester owns the counter, how many steps are left,
  // and whether the completion cycle is showing.
  bit         m_active, m_in_done, m_owner, m_last, m_up, m_wrap;
  int         m_left;
  logic [3:0] m_pos;

  task automatic model_reset();
    m_active = 0; m_in_done = 0; m_owner = 0; m_last = 1;
    m_up = 1; m_wrap = 0; m_left = 0; m_pos = 4'd0;
  endtask

  task automatic model_edge();
    m_wrap = 0;
    if (!m_active) begin
      if (req0 || req1) begin
        if (req0 && req1) m_owner = (m_last == 1'b0);
        else              m_owner = req1;
        m_up      = m_owner ? dir1 : dir0;
        m_left    = m_owner ? int'(len1) : int'(len0);
        m_active  = 1;
        m_in_done = (m_left == 0);
      end
    end else if (m_in_done) begin
      m_last = m_owner;
      m_active = 0;
      m_in_done = 0;
    end else begin
      m_wrap = m_up ? (m_pos == 4'd15) : (m_pos == 4'd0);
      m_pos  = m_up ? m_pos + 4'd1 : m_pos - 4'd1;
      m_left = m_left - 1;
      if (m_left == 0) m_in_done = 1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("gnt0",  int'(gnt0),  int'(m_active && !m_owner));
    chk("gnt1",  int'(gnt1),  int'(m_active && m_owner));
    chk("done0", int'(done0), int'(m_in_done && !m_owner));
    chk("done1", int'(done1), int'(m_in_done && m_owner));
    chk("busy",  int'(busy),  int'(m_active));
    chk("q",     int'(q),     int'(m_pos));
    chk("u_d",   int'(u_d),   int'(m_up));
    chk("tc",    int'(tc),    int'(m_wrap));
    chk("gnt_excl", int'(gnt0 && gnt1), 0);
  endtask

  task automatic drive(input bit r0, input bit d0, input logic [3:0] l0,
                       input bit r1, input bit d1, input logic [3:0] l1);
    req0 = r0; dir0 = d0; len0 = l0; req1 = r1; dir1 = d1; len1 = l1;
  endtask

  // Called at a negedge: apply inputs, advance one edge, compare at next negedge.
  task automatic cyc(input bit r0, input bit d0, input logic [3:0] l0,
                     input bit r1, input bit d1, input logic [3:0] l1);
    drive(r0, d0, l0, r1, d1, l1);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_model();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive(0, 0, 4'd0, 0, 0, 4'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    bit         rst;
    bit         r0, d0; logic [3:0] l0;
    bit         r1, d1; logic [3:0] l1;
    bit         g0, g1, dn0, dn1, bsy;
    logic [3:0] eq;
    bit         eud, etc;
  } vec_t;

  function automatic vec_t mkv(bit rs, bit r0, bit d0, logic [3:0] l0,
                               bit r1, bit d1, logic [3:0] l1,
                               bit g0, bit g1, bit dn0, bit dn1, bit bsy,
                               logic [3:0] eq, bit eud, bit etc);
    vec_t v;
    v.rst = rs; v.r0 = r0; v.d0 = d0; v.l0 = l0; v.r1 = r1; v.d1 = d1; v.l1 = l1;
    v.g0 = g0; v.g1 = g1; v.dn0 = dn0; v.dn1 = dn1; v.bsy = bsy;
    v.eq = eq; v.eud = eud; v.etc = etc;
    return v;
  endfunction

  vec_t tbl[11];
  int   grants[$];
  bit   prev_g0, prev_g1;
  logic [3:0] start_q;

  initial begin
    rst = 1'b1;
    drive(0, 0, 4'd0, 0, 0, 4'd0);
    model_reset();

    //            rst r0 d0 l0    r1 d1 l1     g0 g1 d0 d1 bsy q      ud tc
    tbl[0]  = mkv(1,  0, 0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 4'd0,  1, 0);
    tbl[1]  = mkv(0,  1, 1, 4'd3, 0, 0, 4'd0,  1, 0, 0, 0, 1, 4'd0,  1, 0);
    tbl[2]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  1, 0, 0, 0, 1, 4'd1,  1, 0);
    tbl[3]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  1, 0, 0, 0, 1, 4'd2,  1, 0);
    tbl[4]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  1, 0, 1, 0, 1, 4'd3,  1, 0);
    tbl[5]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 4'd3,  1, 0);
    tbl[6]  = mkv(1,  0, 0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 4'd0,  1, 0);
    tbl[7]  = mkv(0,  0, 0, 4'd0, 1, 0, 4'd2,  0, 1, 0, 0, 1, 4'd0,  0, 0);
    tbl[8]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  0, 1, 0, 0, 1, 4'd15, 0, 1);
    tbl[9]  = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  0, 1, 0, 1, 1, 4'd14, 0, 0);
    tbl[10] = mkv(0,  0, 0, 4'd0, 0, 0, 4'd0,  0, 0, 0, 0, 0, 4'd14, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rst) begin
        do_reset();
      end else begin
        drive(tbl[i].r0, tbl[i].d0, tbl[i].l0, tbl[i].r1, tbl[i].d1, tbl[i].l1);
        @(posedge clk);
        model_edge();
        @(negedge clk);
      end
      chk($sformatf("tbl%0d_gnt0", i),  int'(gnt0),  int'(tbl[i].g0));
      chk($sformatf("tbl%0d_gnt1", i),  int'(gnt1),  int'(tbl[i].g1));
      chk($sformatf("tbl%0d_done0", i), int'(done0), int'(tbl[i].dn0));
      chk($sformatf("tbl%0d_done1", i), int'(done1), int'(tbl[i].dn1));
      chk($sformatf("tbl%0d_busy", i),  int'(busy),  int'(tbl[i].bsy));
      chk($sformatf("tbl%0d_q", i),     int'(q),     int'(tbl[i].eq));
      chk($sformatf("tbl%0d_u_d", i),   int'(u_d),   int'(tbl[i].eud));
      chk($sformatf("tbl%0d_tc", i),    int'(tc),    int'(tbl[i].etc));
    end

    // Round-robin with both requests held: grants must alternate 0,1,0,1.
    do_reset();
    prev_g0 = 0; prev_g1 = 0;
    for (int i = 0; i < 12; i++) begin
      cyc(1, 1, 4'd1, 1, 1, 4'd1);
      if (gnt0 && !prev_g0) grants.push_back(0);
      if (gnt1 && !prev_g1) grants.push_back(1);
      prev_g0 = gnt0; prev_g1 = gnt1;
    end
    chk("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size() && i < 4; i++)
      chk($sformatf("rr_order%0d", i), grants[i], i % 2);
    cyc(0, 0, 4'd0, 0, 0, 4'd0);

    // Zero-length run at q=5.
    do_reset();
    cyc(1, 1, 4'd5, 0, 0, 4'd0);
    for (int i = 0; i < 6; i++) cyc(0, 0, 4'd0, 0, 0, 4'd0);
    chk("zl_pre_q", int'(q), 5);
    cyc(1, 0, 4'd0, 0, 0, 4'd0);
    chk("zl_gnt0", int'(gnt0), 1);
    chk("zl_done0", int'(done0), 1);
    chk("zl_q", int'(q), 5);
    chk("zl_tc", int'(tc), 0);
    cyc(0, 0, 4'd0, 0, 0, 4'd0);
    chk("zl_after_busy", int'(busy), 0);
    chk("zl_after_gnt0", int'(gnt0), 0);

    // Request dropped after one RUN cycle; run still completes with +4.
    start_q = q;
    cyc(1, 1, 4'd4, 0, 0, 4'd0);
    cyc(1, 1, 4'd9, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd0, 0, 0, 4'd0);
    chk("drop_done0", int'(done0), 1);
    chk("drop_q", int'(q), int'(start_q + 4'd4));
    cyc(0, 0, 4'd0, 0, 0, 4'd0);

    // Asynchronous reset partway through a length-8 up run.
    cyc(1, 1, 4'd8, 0, 0, 4'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd0, 0, 0, 4'd0);
    chk("ar_pre_busy", int'(busy), 1);
    #2 rst = 1'b1;
    #1;
    chk("ar_q", int'(q), 0);
    chk("ar_gnt0", int'(gnt0), 0);
    chk("ar_busy", int'(busy), 0);
    chk("ar_done0", int'(done0), 0);
    model_reset();
    @(posedge clk);
    #1 chk("ar_hold_done0", int'(done0), 0);
    @(negedge clk);
    rst = 1'b0;
    check_model();
    cyc(1, 1, 4'd2, 1, 1, 4'd2);
    chk("ar_first_gnt0", int'(gnt0), 1);
    chk("ar_first_gnt1", int'(gnt1), 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 4'd0, 0, 0, 4'd0);

    // Random traffic against the reference model.
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 5)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
